rgmii_rx_status_decoder: RTL and testbench
==========================================

Name: rgmii_rx_status_decoder

Overview:
- Receive-side in-band status decoder for the RGMII PHY interface; runs in the PHY RX clock domain.
- Extracts link, speed and duplex from RXD during inter-frame gaps and debounces them.
- Produces the rx_speed_10/100/1000 and rx_link_up signals that the TX clock manager synchronizes and uses to select the TX clock.

Parameters:
- STABLE_COUNT, 8: consecutive identical valid IFG samples required before outputs update. Must be ≥ 1.
- IFG_GUARD, 2: IFG cycles skipped after rx_dv/rx_er deassert before sampling begins. May be 0.
- ERR_COUNT_WIDTH, 16: width of the invalid-sample counter (optional feature).

Ports:
- clk  input  1  PHY RX clock (2.5/25/125 MHz).
- reset_n  input  1  Reset. Synchronous, active-low.
- rx_dv  input  1  Decoded RX_CTL rising-edge bit (data valid), already DDR-captured.
- rx_er  input  1  RX_DV XOR falling-edge RX_CTL (error/carrier), already DDR-captured.
- rxd  input  4  Rising-edge RXD nibble, already DDR-captured.
- rx_speed_10  output  1  Debounced speed one-hot: 10 Mb/s.
- rx_speed_100  output  1  Debounced speed one-hot: 100 Mb/s.
- rx_speed_1000  output  1  Debounced speed one-hot: 1000 Mb/s.
- rx_link_up  output  1  Debounced link status.
- rx_full_duplex  output  1  Debounced duplex.
- status_changed  output  1  One-cycle pulse when any debounced output changes.
- invalid_count  output  ERR_COUNT_WIDTH  Saturating count of reserved-speed samples (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - Outputs: rx_speed_10=0, rx_speed_100=0, rx_speed_1000=1, rx_link_up=0, rx_full_duplex=0, status_changed=0, invalid_count=0.
  - Internal: state=S_FRAME, match counter=0, candidate=0.
  - Reset mid-count discards all progress.
- Sample decode:
  - link=rxd[0], speed=rxd[2:1] (00=10, 01=100, 10=1000, 11 reserved), duplex=rxd[3].
- A cycle is an IFG cycle only when rx_dv=0 and rx_er=0. rx_dv=0 with rx_er=1 (false carrier/carrier extend) is non-IFG.
- States:
  - S_FRAME: entered on any non-IFG cycle from any state. On IFG, go to S_GUARD with guard counter=0, or to S_SAMPLE directly if IFG_GUARD=0.
  - S_GUARD: count IFG cycles. After IFG_GUARD cycles, go to S_SAMPLE. Non-IFG returns to S_FRAME.
  - S_SAMPLE: each IFG cycle's decoded sample is processed (below). Non-IFG returns to S_FRAME.
- Non-IFG handling: leaving S_SAMPLE preserves candidate and match counter. Debounce spans frames, so status is accepted on a busy link.
- Sample processing in S_SAMPLE:
  - Reserved speed (11): match counter:=0. Sample otherwise ignored. invalid_count increments if the feature is enabled.
  - Sample ≠ candidate: candidate:=sample, match counter:=1.
  - Sample = candidate: match counter increments, saturating at STABLE_COUNT. Counter width is $clog2(STABLE_COUNT+1).
- Output update:
  - Fires in the cycle after the match counter reaches STABLE_COUNT, or when it already equals STABLE_COUNT and candidate ≠ outputs.
  - Outputs:=candidate decoded to one-hot speed.
  - status_changed=1 for exactly that cycle, only if a value actually changed.
- Latency: N identical IFG samples starting at cycle t put the new outputs in effect at t+N. With STABLE_COUNT=1, outputs update the cycle after the sample.
- Invariant: speed outputs are always exactly one-hot, including the reset value.
- Link down: rx_link_up=0 is accepted like any status. The last speed stays reported as decoded from the same sample.

Optional Feature:
- Macro: RX_STATUS_ERR_COUNT_EN.
- Defined: invalid_count increments on each reserved-speed sample in S_SAMPLE and saturates at all-ones. Cleared only by reset.
- Undefined: invalid_count is tied to 0 and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Reset, then IFG with rxd=4'b1101 held for 8 cycles (STABLE_COUNT=8, IFG_GUARD=2) -> after 2 guard + 8 samples, rx_speed_1000=1, rx_link_up=1, rx_full_duplex=1, status_changed pulses once. No second pulse while holding.
- After 1000/up/full is locked, 5 IFG cycles of rxd=4'b1011, then rx_dv=1 for 20 cycles, then IFG rxd=4'b1011 again -> rx_speed_100=1 asserts after 2 guard + 3 more samples (5+3=8). The count is preserved across the frame.
- Alternate rxd=4'b1101 and 4'b1011 every cycle for 100 cycles -> outputs never change, status_changed stays 0.
- 10 IFG cycles of rxd=4'b0111 (reserved speed) -> no output change. With RX_STATUS_ERR_COUNT_EN, invalid_count=8 (10 minus 2 guard); without it, invalid_count=0.
- rx_dv=0, rx_er=1, rxd=4'hE for 50 cycles -> treated as non-IFG, no sampling, outputs unchanged.
- Assert reset_n=0 for 1 cycle when the match counter is at 7 -> outputs return to reset values. A full 8 fresh samples after guard are required before the next update.

Source files
------------

// File: rtl/rgmii_rx_status_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rgmii_rx_status_decoder
// Purpose  : Decodes RGMII in-band status (link/speed/duplex) carried on RXD
//            during inter-frame gaps, debounces it, and presents one-hot
//            speed plus link/duplex for the TX clock manager.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   PHY RX clock (2.5/25/125 MHz)
//   reset_n        in   synchronous active-low reset
//   rx_dv          in   data valid (rising-edge RX_CTL)
//   rx_er          in   error/carrier (RX_DV xor falling-edge RX_CTL)
//   rxd[3:0]       in   rising-edge RXD nibble
//   rx_speed_10    out  debounced speed one-hot, 10 Mb/s
//   rx_speed_100   out  debounced speed one-hot, 100 Mb/s
//   rx_speed_1000  out  debounced speed one-hot, 1000 Mb/s
//   rx_link_up     out  debounced link status
//   rx_full_duplex out  debounced duplex
//   status_changed out  one-cycle pulse when a debounced output changes
//   invalid_count  out  saturating count of reserved-speed samples
// Optional : define RX_STATUS_ERR_COUNT_EN to build the invalid-sample
//            counter; otherwise invalid_count is tied to zero.
// ============================================================================
module rgmii_rx_status_decoder #(
  parameter int STABLE_COUNT    = 8,
  parameter int IFG_GUARD       = 2,
  parameter int ERR_COUNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rx_dv,
  input  logic                       rx_er,
  input  logic [3:0]                 rxd,
  output logic                       rx_speed_10,
  output logic                       rx_speed_100,
  output logic                       rx_speed_1000,
  output logic                       rx_link_up,
  output logic                       rx_full_duplex,
  output logic                       status_changed,
  output logic [ERR_COUNT_WIDTH-1:0] invalid_count
);

  localparam int c_MATCH_W = $clog2(STABLE_COUNT + 1);
  localparam int c_GUARD_W = (IFG_GUARD < 2) ? 1 : $clog2(IFG_GUARD + 1);
  localparam logic [c_MATCH_W-1:0] c_STABLE = c_MATCH_W'(STABLE_COUNT);
  localparam logic [c_GUARD_W-1:0] c_GUARD  = c_GUARD_W'(IFG_GUARD);

  typedef enum logic [1:0] {
    S_FRAME  = 2'd0,
    S_GUARD  = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_GUARD_W-1:0]  r_guard_cnt;
  logic [3:0]            r_cand;
  logic [c_MATCH_W-1:0]  r_match;

  logic                  w_ifg;
  logic                  w_sample_en;
  logic                  w_reserved;
  logic [3:0]            w_next_cand;
  logic [c_MATCH_W-1:0]  w_next_match;
  logic [1:0]            w_out_speed;
  logic [3:0]            w_out_code;
  logic                  w_update;

  assign w_ifg      = ~rx_dv & ~rx_er;
  assign w_reserved = (rxd[2:1] == 2'b11);

  // With no guard interval the first IFG cycle is already a valid sample,
  // even though the FSM is still leaving S_FRAME during it.
  assign w_sample_en = w_ifg &&
                       ((r_state == S_SAMPLE) ||
                        ((IFG_GUARD == 0) && (r_state == S_FRAME)));

  always_comb begin
    w_next_cand  = r_cand;
    w_next_match = r_match;
    if (w_sample_en) begin
      if (w_reserved) begin
        w_next_match = '0;
      end else if (rxd != r_cand) begin
        w_next_cand  = rxd;
        w_next_match = c_MATCH_W'(1);
      end else if (r_match != c_STABLE) begin
        w_next_match = r_match + c_MATCH_W'(1);
      end
    end
  end

  // Re-encode the current outputs in RXD format so they compare directly
  // against the candidate sample.
  assign w_out_speed = rx_speed_10  ? 2'b00 :
                       rx_speed_100 ? 2'b01 : 2'b10;
  assign w_out_code  = {rx_full_duplex, w_out_speed, rx_link_up};

  // Evaluated on next-state values so the outputs land on the same edge that
  // takes the match counter to STABLE_COUNT (N samples -> effect at t+N).
  assign w_update = (w_next_match == c_STABLE) && (w_next_cand != w_out_code);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= S_FRAME;
      r_guard_cnt    <= '0;
      r_cand         <= '0;
      r_match        <= '0;
      rx_speed_10    <= 1'b0;
      rx_speed_100   <= 1'b0;
      rx_speed_1000  <= 1'b1;
      rx_link_up     <= 1'b0;
      rx_full_duplex <= 1'b0;
      status_changed <= 1'b0;
    end else begin
      case (r_state)
        S_FRAME: begin
          // The IFG cycle that ends the frame is the first guard cycle.
          if (w_ifg) begin
            r_guard_cnt <= c_GUARD_W'(1);
            r_state     <= (IFG_GUARD <= 1) ? S_SAMPLE : S_GUARD;
          end
        end
        S_GUARD: begin
          if (!w_ifg) begin
            r_state <= S_FRAME;
          end else if (r_guard_cnt == c_GUARD - c_GUARD_W'(1)) begin
            r_state <= S_SAMPLE;
          end else begin
            r_guard_cnt <= r_guard_cnt + c_GUARD_W'(1);
          end
        end
        S_SAMPLE: begin
          if (!w_ifg) begin
            r_state <= S_FRAME;
          end
        end
        default: r_state <= S_FRAME;
      endcase

      // Candidate and match count survive frames so status debounces on a
      // busy link.
      r_cand         <= w_next_cand;
      r_match        <= w_next_match;
      status_changed <= w_update;
      if (w_update) begin
        rx_speed_10    <= (w_next_cand[2:1] == 2'b00);
        rx_speed_100   <= (w_next_cand[2:1] == 2'b01);
        rx_speed_1000  <= (w_next_cand[2:1] == 2'b10);
        rx_link_up     <= w_next_cand[0];
        rx_full_duplex <= w_next_cand[3];
      end
    end
  end

`ifdef RX_STATUS_ERR_COUNT_EN
  logic [ERR_COUNT_WIDTH-1:0] r_invalid_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_invalid_cnt <= '0;
    end else if (w_sample_en && w_reserved && (r_invalid_cnt != '1)) begin
      r_invalid_cnt <= r_invalid_cnt + ERR_COUNT_WIDTH'(1);
    end
  end

  assign invalid_count = r_invalid_cnt;
`else
  assign invalid_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgmii_rx_status_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgmii_rx_status_decoder
// Purpose  : Scoreboard bench for rgmii_rx_status_decoder with the default
//            STABLE_COUNT=8, IFG_GUARD=2. Stimulus pushes the expected
//            status and the edge at which it must appear; a monitor pops and
//            compares on every status_changed pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgmii_rx_status_decoder;

  localparam logic [4:0] c_RESET   = 5'b00100; // {10,100,1000,link,duplex}
  localparam logic [4:0] c_G_UP_FD = 5'b00111;
  localparam logic [4:0] c_M_UP_FD = 5'b01011;
`ifdef RX_STATUS_ERR_COUNT_EN
  localparam int c_INV_EXP = 8;
`else
  localparam int c_INV_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_dv;
  logic        rx_er;
  logic [3:0]  rxd;
  logic        rx_speed_10;
  logic        rx_speed_100;
  logic        rx_speed_1000;
  logic        rx_link_up;
  logic        rx_full_duplex;
  logic        status_changed;
  logic [15:0] invalid_count;
  logic [4:0]  w_st;

  typedef struct {
    int         edge_i;
    logic [4:0] val;
  } exp_t;

  exp_t q[$];
  int   edge_n     = 0;
  int   vectors    = 0;
  int   miscompares = 0;

  rgmii_rx_status_decoder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_dv          (rx_dv),
    .rx_er          (rx_er),
    .rxd            (rxd),
    .rx_speed_10    (rx_speed_10),
    .rx_speed_100   (rx_speed_100),
    .rx_speed_1000  (rx_speed_1000),
    .rx_link_up     (rx_link_up),
    .rx_full_duplex (rx_full_duplex),
    .status_changed (status_changed),
    .invalid_count  (invalid_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  assign w_st = {rx_speed_10, rx_speed_100, rx_speed_1000, rx_link_up, rx_full_duplex};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic dv, input logic er, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      rx_dv = dv;
      rx_er = er;
      rxd   = d;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_update(input int after, input logic [4:0] val);
    exp_t e;
    e.edge_i = edge_n + after;
    e.val    = val;
    q.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the queue in both timing and
  // value; an expectation whose edge has passed without a pulse is a miss.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].edge_i < edge_n) begin
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missed_update: no pulse at edge %0d (now %0d), expected status %05b",
               e.edge_i, edge_n, e.val);
    end
    if (status_changed === 1'b1) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: pulse at edge %0d status %05b, none expected", edge_n, w_st);
      end else begin
        e = q.pop_front();
        if (e.edge_i != edge_n || e.val !== w_st) begin
          miscompares++;
          $display("FAIL update: edge %0d status %05b, expected edge %0d status %05b",
                   edge_n, w_st, e.edge_i, e.val);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    rx_dv   = 1'b1;
    rx_er   = 1'b0;
    rxd     = 4'h0;
    apply(1'b1, 1'b0, 4'h0, 3);
    check("reset_status", 32'(w_st), 32'(c_RESET));
    check("reset_pulse", 32'(status_changed), 32'd0);
    check("reset_invalid", 32'(invalid_count), 32'd0);
    reset_n = 1'b1;

    // Lock 1000/up/full: 2 guard + 8 samples.
    expect_update(10, c_G_UP_FD);
    apply(1'b0, 1'b0, 4'hD, 10);
    check("lock_1000", 32'(w_st), 32'(c_G_UP_FD));
    apply(1'b0, 1'b0, 4'hD, 20);
    check("hold_1000", 32'(w_st), 32'(c_G_UP_FD));
    check("hold_no_pulse", 32'(status_changed), 32'd0);

    // 5 samples, a frame, then 2 guard + 3 samples completes the count.
    apply(1'b0, 1'b0, 4'hB, 5);
    check("partial_100", 32'(w_st), 32'(c_G_UP_FD));
    apply(1'b1, 1'b0, 4'hB, 20);
    expect_update(5, c_M_UP_FD);
    apply(1'b0, 1'b0, 4'hB, 4);
    check("before_100", 32'(w_st), 32'(c_G_UP_FD));
    apply(1'b0, 1'b0, 4'hB, 1);
    check("lock_100", 32'(w_st), 32'(c_M_UP_FD));
    apply(1'b0, 1'b0, 4'hB, 5);

    // Alternating samples never debounce.
    for (int i = 0; i < 100; i++) begin
      apply(1'b0, 1'b0, (i % 2 == 1) ? 4'hB : 4'hD, 1);
    end
    check("alternate_hold", 32'(w_st), 32'(c_M_UP_FD));

    // Reserved speed: frame first so exactly 8 samples follow the guard.
    apply(1'b1, 1'b0, 4'h0, 3);
    apply(1'b0, 1'b0, 4'h7, 10);
    check("reserved_hold", 32'(w_st), 32'(c_M_UP_FD));
    check("reserved_count", 32'(invalid_count), 32'(c_INV_EXP));

    // False carrier is non-IFG: nothing sampled.
    apply(1'b0, 1'b1, 4'hE, 50);
    check("carrier_hold", 32'(w_st), 32'(c_M_UP_FD));
    check("carrier_count", 32'(invalid_count), 32'(c_INV_EXP));

    // Reach match count 7, then reset discards it.
    apply(1'b0, 1'b0, 4'hD, 9);
    check("count7_hold", 32'(w_st), 32'(c_M_UP_FD));
    reset_n = 1'b0;
    apply(1'b0, 1'b0, 4'hD, 1);
    check("midreset_status", 32'(w_st), 32'(c_RESET));
    check("midreset_pulse", 32'(status_changed), 32'd0);
    check("midreset_invalid", 32'(invalid_count), 32'd0);
    reset_n = 1'b1;
    expect_update(10, c_G_UP_FD);
    apply(1'b0, 1'b0, 4'hD, 9);
    check("post_reset_wait", 32'(w_st), 32'(c_RESET));
    apply(1'b0, 1'b0, 4'hD, 1);
    check("post_reset_lock", 32'(w_st), 32'(c_G_UP_FD));
    apply(1'b0, 1'b0, 4'hD, 3);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
